// File: rtl/lcd_seq_pkg.sv
// Shared types, init ROM contents and command decode for the HD44780 sequencer.
package lcd_seq_pkg;

  localparam int TMR_W = 20;
  localparam int ROM_DEPTH = 8;
  localparam logic [2:0] ROM_LAST = 3'd7;
  localparam logic [2:0] ROM_FIRST_POLL = 3'd4;

  typedef enum logic [3:0] {
    S_PWRUP,
    S_ISSUE,
    S_ACK,
    S_DONE,
    S_DELAY,
    S_IDLE,
    S_POLL,
    S_PACK,
    S_PDONE
  } state_e;

  typedef enum logic [1:0] {
    DSEL_CMD,
    DSEL_INIT1,
    DSEL_CLEAR
  } dsel_e;

  typedef struct packed {
    logic [7:0] data;
    dsel_e      dsel;
  } rom_entry_t;

  localparam rom_entry_t INIT_ROM [ROM_DEPTH] = '{
    '{data: 8'h38, dsel: DSEL_INIT1},
    '{data: 8'h38, dsel: DSEL_CMD},
    '{data: 8'h38, dsel: DSEL_CMD},
    '{data: 8'h38, dsel: DSEL_CMD},
    '{data: 8'h08, dsel: DSEL_CMD},
    '{data: 8'h01, dsel: DSEL_CLEAR},
    '{data: 8'h06, dsel: DSEL_CMD},
    '{data: 8'h0C, dsel: DSEL_CMD}
  };

  // Clear (0x01) and return-home (0x02/0x03) need the long execution time.
  function automatic logic is_clear_home(input logic rs, input logic [7:0] data);
    return !rs && ((data == 8'h01) || (data == 8'h02) || (data == 8'h03));
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// 20-bit down-counter shared by the power-up wait, post-command delays and handshake timeout.
module lcd_delay_timer
  import lcd_seq_pkg::*;
#(
  parameter logic [TMR_W-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [TMR_W-1:0] value_i,
  output logic             expired_o
);

  logic [TMR_W-1:0] count_q;
  logic [TMR_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // Reset loads the power-up wait so the sequencer starts counting immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= RESET_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/lcd_sequencer.sv
// HD44780 init + host-write sequencer driving Lcd_Controller strobes.
// Define LCD_SEQ_BUSY_POLL_EN to replace timed delays with busy-flag polling (ROM 4-7, host writes).
module lcd_sequencer
  import lcd_seq_pkg::*;
#(
  parameter int unsigned T_POWERUP = 750000,
  parameter int unsigned T_INIT1   = 205000,
  parameter int unsigned T_CMD     = 2000,
  parameter int unsigned T_CLEAR   = 82000,
  parameter int unsigned T_ACK_TO  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       host_valid,
  input  logic       host_rs,
  input  logic [7:0] host_data,
  output logic       host_ready,
  output logic       init_done,
  output logic       lcd_err,
  output logic       lcd_ncs,
  output logic       lcd_nwr,
  output logic       lcd_nrd,
  output logic       lcd_rs,
  output logic [7:0] lcd_data,
  input  logic [7:0] lcd_din,
  input  logic       lcd_rdy
);

  // A load of N-1 yields N cycles before expiry.
  localparam logic [TMR_W-1:0] LD_POWERUP = TMR_W'(T_POWERUP - 1);
  localparam logic [TMR_W-1:0] LD_INIT1   = TMR_W'(T_INIT1 - 1);
  localparam logic [TMR_W-1:0] LD_CMD     = TMR_W'(T_CMD - 1);
  localparam logic [TMR_W-1:0] LD_CLEAR   = TMR_W'(T_CLEAR - 1);
  localparam logic [TMR_W-1:0] LD_ACK_TO  = TMR_W'(T_ACK_TO - 1);

  state_e           state_q, state_d;
  logic [2:0]       idx_q;
  logic             rs_q;
  logic [7:0]       data_q;
  logic             init_done_q;
  logic             err_q;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_value;
  logic             tmr_expired;
  logic             start_rom, advance, err_set, xfer_end, host_accept;
  dsel_e            dsel;
  logic [TMR_W-1:0] delay_ld;
  logic [2:0]       idx_next;
  logic             din_unused;

  lcd_delay_timer #(
    .RESET_VAL(LD_POWERUP)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load_i   (tmr_load),
    .value_i  (tmr_value),
    .expired_o(tmr_expired)
  );

  assign idx_next = idx_q + 3'd1;

  // ROM entries carry their own delay class; host writes decode clear/home.
  always_comb begin
    dsel = DSEL_CMD;
    if (!init_done_q) begin
      dsel = INIT_ROM[idx_q].dsel;
    end else if (is_clear_home(rs_q, data_q)) begin
      dsel = DSEL_CLEAR;
    end
    case (dsel)
      DSEL_INIT1: delay_ld = LD_INIT1;
      DSEL_CLEAR: delay_ld = LD_CLEAR;
      default:    delay_ld = LD_CMD;
    endcase
  end

`ifdef LCD_SEQ_BUSY_POLL_EN
  logic use_poll;
  assign use_poll   = init_done_q || (idx_q >= ROM_FIRST_POLL);
  assign din_unused = ^lcd_din[6:0];
`else
  assign din_unused = ^lcd_din;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_PWRUP;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every signal assigned in this block gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_d     = state_q;
    tmr_load    = 1'b0;
    tmr_value   = delay_ld;
    start_rom   = 1'b0;
    advance     = 1'b0;
    err_set     = 1'b0;
    xfer_end    = 1'b0;
    host_accept = 1'b0;
    case (state_q)
      S_PWRUP: begin
        if (tmr_expired) begin
          start_rom = 1'b1;
          state_d   = S_ISSUE;
        end
      end
      S_IDLE: begin
        if (host_valid) begin
          host_accept = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d   = S_ACK;
        tmr_load  = 1'b1;
        tmr_value = LD_ACK_TO;
      end
      S_ACK: begin
        if (!lcd_rdy) begin
          state_d   = S_DONE;
          tmr_load  = 1'b1;
          tmr_value = LD_ACK_TO;
        end else if (tmr_expired) begin
          err_set  = 1'b1;
          xfer_end = 1'b1;
        end
      end
      S_DONE: begin
        if (lcd_rdy) begin
          xfer_end = 1'b1;
        end else if (tmr_expired) begin
          err_set  = 1'b1;
          xfer_end = 1'b1;
        end
      end
      S_DELAY: begin
        if (tmr_expired) begin
          advance = 1'b1;
        end
      end
`ifdef LCD_SEQ_BUSY_POLL_EN
      S_POLL: begin
        state_d   = S_PACK;
        tmr_load  = 1'b1;
        tmr_value = LD_ACK_TO;
      end
      S_PACK: begin
        if (!lcd_rdy) begin
          state_d   = S_PDONE;
          tmr_load  = 1'b1;
          tmr_value = LD_ACK_TO;
        end else if (tmr_expired) begin
          err_set = 1'b1;
          advance = 1'b1;
        end
      end
      S_PDONE: begin
        if (lcd_rdy) begin
          if (lcd_din[7]) begin
            state_d = S_POLL;
          end else begin
            advance = 1'b1;
          end
        end else if (tmr_expired) begin
          err_set = 1'b1;
          advance = 1'b1;
        end
      end
`endif
      default: state_d = S_PWRUP;
    endcase

    if (xfer_end) begin
      state_d   = S_DELAY;
      tmr_load  = 1'b1;
      tmr_value = delay_ld;
`ifdef LCD_SEQ_BUSY_POLL_EN
      if (use_poll) begin
        state_d  = S_POLL;
        tmr_load = 1'b0;
      end
`endif
    end

    if (advance) begin
      state_d = (init_done_q || (idx_q == ROM_LAST)) ? S_IDLE : S_ISSUE;
    end
  end

  always_comb begin
    lcd_ncs = 1'b1;
    lcd_nwr = 1'b1;
    lcd_nrd = 1'b1;
    lcd_rs  = rs_q;
    case (state_q)
      S_ISSUE, S_ACK: begin
        lcd_ncs = 1'b0;
        lcd_nwr = 1'b0;
      end
`ifdef LCD_SEQ_BUSY_POLL_EN
      S_POLL, S_PACK: begin
        lcd_ncs = 1'b0;
        lcd_nrd = 1'b0;
        lcd_rs  = 1'b0;
      end
      S_PDONE: lcd_rs = 1'b0;
`endif
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, independent of block order.
  // NOTE: INIT_ROM is a constant table, so it has no storage that would need a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q       <= '0;
      rs_q        <= 1'b0;
      data_q      <= '0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (err_set) begin
        err_q <= 1'b1;
      end
      if (host_accept) begin
        rs_q   <= host_rs;
        data_q <= host_data;
      end
      if (start_rom) begin
        idx_q  <= '0;
        rs_q   <= 1'b0;
        data_q <= INIT_ROM[0].data;
      end
      if (advance && !init_done_q) begin
        if (idx_q == ROM_LAST) begin
          init_done_q <= 1'b1;
        end else begin
          idx_q  <= idx_next;
          data_q <= INIT_ROM[idx_next].data;
        end
      end
    end
  end

  assign host_ready = (state_q == S_IDLE);
  assign init_done  = init_done_q;
  assign lcd_err    = err_q;
  assign lcd_data   = data_q;

endmodule

// File: tb/tb_lcd_sequencer.sv
// Scoreboard bench for lcd_sequencer with a behavioural Lcd_Controller responder.
module tb_lcd_sequencer;

  localparam int T_POWERUP = 60;
  localparam int T_INIT1   = 40;
  localparam int T_CMD     = 12;
  localparam int T_CLEAR   = 30;
  localparam int T_ACK_TO  = 10;
  localparam int WAIT_MAX  = 2000;

  logic       clk = 1'b0;
  logic       rst;
  logic       host_valid, host_rs;
  logic [7:0] host_data;
  logic       host_ready, init_done, lcd_err;
  logic       lcd_ncs, lcd_nwr, lcd_nrd, lcd_rs;
  logic [7:0] lcd_data;
  logic [7:0] lcd_din;
  logic       lcd_rdy;

  always #5 clk = ~clk;

  lcd_sequencer #(
    .T_POWERUP(T_POWERUP),
    .T_INIT1  (T_INIT1),
    .T_CMD    (T_CMD),
    .T_CLEAR  (T_CLEAR),
    .T_ACK_TO (T_ACK_TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .host_valid(host_valid),
    .host_rs   (host_rs),
    .host_data (host_data),
    .host_ready(host_ready),
    .init_done (init_done),
    .lcd_err   (lcd_err),
    .lcd_ncs   (lcd_ncs),
    .lcd_nwr   (lcd_nwr),
    .lcd_nrd   (lcd_nrd),
    .lcd_rs    (lcd_rs),
    .lcd_data  (lcd_data),
    .lcd_din   (lcd_din),
    .lcd_rdy   (lcd_rdy)
  );

  typedef struct {
    bit       rs;
    bit [7:0] data;
    int       dly;
    bit       timeout;
    bit       init_exp;
  } exp_t;

  exp_t     q[$];
  int       tests = 0;
  int       fails = 0;
  int       cyc = 0;
  int       rel_cyc = 0;
  int       model_n = 0;
  int       stall_at = 0;
  bit [7:0] rom_bytes [8] = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint lo, input longint hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  // Execution time each write must be followed by, straight from the HD44780 rules.
  function automatic int ref_delay(input int rom_idx, input bit rs, input bit [7:0] d);
    if (rom_idx == 0) return T_INIT1;
    if (!rs && d >= 8'h01 && d <= 8'h03) return T_CLEAR;
    return T_CMD;
  endfunction

  task automatic push_rom();
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.rs = 1'b0; e.data = rom_bytes[i]; e.dly = ref_delay(i, 1'b0, rom_bytes[i]);
      e.timeout = 1'b0; e.init_exp = 1'b0;
      q.push_back(e);
    end
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!host_ready && n < WAIT_MAX) begin
      @(posedge clk); #2;
      n++;
    end
    check(name, host_ready, 1, 1);
  endtask

  task automatic send(input bit rs, input bit [7:0] d, input bit stall);
    int   n = 0;
    exp_t e;
    if (stall) stall_at = model_n + 1;
    @(posedge clk); #2;
    host_valid = 1'b1; host_rs = rs; host_data = d;
    while (!host_ready && n < WAIT_MAX) begin
      @(posedge clk); #2;
      n++;
    end
    if (!host_ready) begin
      check("host_ready wait", 0, 1, 1);
      host_valid = 1'b0;
    end else begin
      e.rs = rs; e.data = d; e.dly = ref_delay(-1, rs, d);
      e.timeout = stall; e.init_exp = 1'b1;
      q.push_back(e);
      @(posedge clk); #2;
      host_valid = 1'b0;
      check("ready drop after accept", host_ready, 0, 0);
    end
  endtask

  // Lcd_Controller model: drop RDY a few cycles into a strobe, raise it after release.
  initial begin
    int d;
    int n;
    lcd_rdy = 1'b1;
    forever begin
      @(posedge clk); #2;
      if (!rst && !lcd_ncs) begin
        model_n++;
        if (model_n != stall_at) begin
          d = $urandom_range(1, 3);
          repeat (d) @(posedge clk);
          #2 lcd_rdy = 1'b0;
        end
        n = 0;
        while (!lcd_ncs && n < 200) begin
          @(posedge clk); #2;
          n++;
        end
        d = $urandom_range(0, 3);
        if (d > 0) begin
          repeat (d) @(posedge clk);
          #2;
        end
        lcd_rdy = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on every strobe and times each post-write delay.
  bit   m_ncs, m_rdy, m_ready, m_inx, m_await, m_armed, m_first, m_unstable, m_err;
  int   m_low, m_tstart, m_dly;
  exp_t m_cur;

  initial begin
    m_ncs = 1; m_rdy = 1; m_ready = 0; m_inx = 0; m_await = 0; m_armed = 0;
    m_first = 1; m_unstable = 0; m_err = 0; m_low = 0; m_tstart = 0; m_dly = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_ncs = 1; m_rdy = 1; m_ready = 0; m_inx = 0; m_await = 0;
        m_armed = 0; m_first = 1; m_err = 0;
      end else begin
        if (m_ncs && !lcd_ncs) begin
          if (m_first) begin
            check("power-up wait", cyc - rel_cyc, T_POWERUP - 2, T_POWERUP + 2);
            m_first = 0;
          end
          if (m_armed) begin
            check("delay before next strobe", cyc - m_tstart, m_dly, m_dly + 1);
            m_armed = 0;
          end
          check("nwr low with ncs", lcd_nwr, 0, 0);
          check("nrd idle", lcd_nrd, 1, 1);
          if (q.size() == 0) begin
            check("unexpected strobe", 1, 0, 0);
          end else begin
            m_cur = q.pop_front();
            check("lcd_rs", lcd_rs, m_cur.rs, m_cur.rs);
            check("lcd_data", lcd_data, m_cur.data, m_cur.data);
            check("init_done at strobe", init_done, m_cur.init_exp, m_cur.init_exp);
          end
          m_inx = 1; m_low = cyc; m_unstable = 0;
        end
        if ((m_inx || m_await) && (lcd_rs != m_cur.rs || lcd_data != m_cur.data)) m_unstable = 1;
        if (m_inx && lcd_ncs) begin
          m_inx = 0;
          check("nwr release", lcd_nwr, 1, 1);
          if (m_cur.timeout) begin
            check("timeout strobe width", cyc - m_low, T_ACK_TO + 1, T_ACK_TO + 2);
            m_err = 1;
            check("lcd_err after timeout", lcd_err, 1, 1);
            check("bus stable", m_unstable, 0, 0);
            m_tstart = cyc - 1; m_dly = m_cur.dly; m_armed = 1;
          end else begin
            check("strobe width", cyc - m_low, 2, T_ACK_TO);
            check("lcd_err sticky", lcd_err, m_err, m_err);
            m_await = 1;
          end
        end
        if (m_await && !m_rdy && lcd_rdy) begin
          m_await = 0;
          check("bus stable", m_unstable, 0, 0);
          m_tstart = cyc; m_dly = m_cur.dly; m_armed = 1;
        end
        if (!m_ready && host_ready) begin
          if (m_armed) begin
            check("delay before host_ready", cyc - m_tstart, m_dly, m_dly + 1);
            m_armed = 0;
          end
          check("init_done at ready", init_done, 1, 1);
        end
        m_ncs = lcd_ncs; m_rdy = lcd_rdy; m_ready = host_ready;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit       rs;
    bit [7:0] d;
    int       base;
    int       n;
    rst = 1'b1; host_valid = 1'b0; host_rs = 1'b0; host_data = 8'h00; lcd_din = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    check("reset ncs", lcd_ncs, 1, 1);
    check("reset nwr", lcd_nwr, 1, 1);
    check("reset nrd", lcd_nrd, 1, 1);
    check("reset rs", lcd_rs, 0, 0);
    check("reset data", lcd_data, 0, 0);
    check("reset host_ready", host_ready, 0, 0);
    check("reset init_done", init_done, 0, 0);
    check("reset lcd_err", lcd_err, 0, 0);
    push_rom();
    rel_cyc = cyc;
    rst = 1'b0;
    wait_ready("init completes");
    check("init_done after init", init_done, 1, 1);
    check("no error after init", lcd_err, 0, 0);

    send(1'b1, 8'h41, 1'b0);
    send(1'b0, 8'h01, 1'b0);
    send(1'b0, 8'h02, 1'b0);
    send(1'b0, 8'h03, 1'b0);
    send(1'b1, 8'h01, 1'b0);
    for (int i = 0; i < 16; i++) begin
      rs = 1'($urandom_range(0, 1));
      d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
      send(rs, d, 1'b0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    send(1'b1, 8'h55, 1'b1);
    wait_ready("ready after timeout");
    check("lcd_err set", lcd_err, 1, 1);
    send(1'b0, 8'h0C, 1'b0);
    wait_ready("ready after recovery");
    check("lcd_err stays set", lcd_err, 1, 1);

    // Restart, then reset again while ROM entry 2 sits in its handshake.
    @(posedge clk); #2;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    q.delete();
    push_rom();
    stall_at = model_n + 3;
    rel_cyc = cyc;
    rst = 1'b0;
    n = 0;
    while (model_n < stall_at && n < WAIT_MAX) begin
      @(negedge clk);
      n++;
    end
    check("reached ROM entry 2", model_n, stall_at, stall_at);
    repeat (3) @(posedge clk);
    #2;
    check("strobe still low before reset", lcd_ncs, 0, 0);
    rst = 1'b1;
    #1;
    check("async ncs release", lcd_ncs, 1, 1);
    check("async nwr release", lcd_nwr, 1, 1);
    check("err cleared by reset", lcd_err, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    q.delete();
    push_rom();
    stall_at = 0;
    base = model_n;
    rel_cyc = cyc;
    rst = 1'b0;
    wait_ready("re-init completes");
    check("replayed ROM writes", model_n - base, 8, 8);
    check("init_done after re-init", init_done, 1, 1);
    send(1'b1, 8'h7E, 1'b0);
    wait_ready("final ready");
    check("scoreboard drained", q.size(), 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
